// File: rtl/bsg_manycore_vcache_wh_concentrator.sv
// rtl/bsg_manycore_vcache_wh_concentrator.sv - concentrates vcache DMA wormhole channels onto one link.
// Optional stall counter: define BSG_WH_CONCENTRATOR_STALL_CNT_EN.
module bsg_manycore_vcache_wh_concentrator #(
  parameter int num_in_p     = 4,
  parameter int flit_width_p = 32,
  parameter int cord_width_p = 8,
  parameter int len_width_p  = 4,
  parameter int cid_width_p  = 2
) (
  input  logic                                   clk_i,
  input  logic                                   reset_n_i,

  input  logic [num_in_p-1:0]                    fwd_v_i,
  input  logic [num_in_p-1:0][flit_width_p-1:0]  fwd_data_i,
  output logic [num_in_p-1:0]                    fwd_ready_and_o,

  output logic                                   fwd_v_o,
  output logic [flit_width_p-1:0]                fwd_data_o,
  input  logic                                   fwd_ready_and_i,

  input  logic                                   rev_v_i,
  input  logic [flit_width_p-1:0]                rev_data_i,
  output logic                                   rev_ready_and_o,

  output logic [num_in_p-1:0]                    rev_v_o,
  output logic [num_in_p-1:0][flit_width_p-1:0]  rev_data_o,
  input  logic [num_in_p-1:0]                    rev_ready_and_i,

  output logic [31:0]                            stall_count_o
);

  localparam int lg_lp   = $clog2(num_in_p);
  localparam int len_lsb = cord_width_p;
  localparam int cid_lsb = cord_width_p + len_width_p;

  if (cid_width_p < lg_lp || num_in_p < 2 || (1 << lg_lp) != num_in_p) begin : g_bad_cfg
    $error("bsg_manycore_vcache_wh_concentrator: illegal num_in_p/cid_width_p");
  end

  typedef enum logic {F_IDLE, F_BUSY} f_state_e;
  typedef enum logic {R_IDLE, R_BUSY} r_state_e;

  f_state_e               f_state, f_state_n;
  logic [lg_lp-1:0]       rr_ptr, rr_ptr_n;
  logic [lg_lp-1:0]       f_lock, f_lock_n;
  logic [len_width_p-1:0] fcnt, fcnt_n;
  logic [lg_lp-1:0]       f_idx, f_grant, f_sel;
  logic                   f_found, f_act, f_xfer;
  logic [len_width_p-1:0] f_len;

  r_state_e               r_state, r_state_n;
  logic [lg_lp-1:0]       r_lock, r_lock_n;
  logic [len_width_p-1:0] rcnt, rcnt_n;
  logic [lg_lp-1:0]       r_dest, r_sel;
  logic                   r_xfer;
  logic [len_width_p-1:0] r_len;

  // Forward path: round-robin grant in idle, locked channel while a packet is in flight.
  always_comb begin
    f_idx   = '0;
    f_grant = rr_ptr;
    f_found = 1'b0;
    for (int i = 0; i < num_in_p; i++) begin
      f_idx = rr_ptr + lg_lp'(i);
      if (!f_found && fwd_v_i[f_idx]) begin
        f_found = 1'b1;
        f_grant = f_idx;
      end
    end
    f_sel           = (f_state == F_BUSY) ? f_lock : f_grant;
    f_act           = reset_n_i & ((f_state == F_BUSY) | f_found);
    fwd_v_o         = f_act & fwd_v_i[f_sel];
    fwd_data_o      = fwd_data_i[f_sel];
    fwd_ready_and_o = '0;
    if (f_act) fwd_ready_and_o[f_sel] = fwd_ready_and_i;
    f_xfer          = fwd_v_o & fwd_ready_and_i;
    f_len           = fwd_data_o[cid_lsb-1:len_lsb];

    f_state_n = f_state;
    rr_ptr_n  = rr_ptr;
    f_lock_n  = f_lock;
    fcnt_n    = fcnt;
    case (f_state)
      F_IDLE: if (f_xfer) begin
        if (f_len == '0) begin
          rr_ptr_n = f_grant + lg_lp'(1);
        end else begin
          f_state_n = F_BUSY;
          f_lock_n  = f_grant;
          fcnt_n    = f_len;
        end
      end
      F_BUSY: if (f_xfer) begin
        fcnt_n = fcnt - len_width_p'(1);
        if (fcnt == len_width_p'(1)) begin
          f_state_n = F_IDLE;
          rr_ptr_n  = f_lock + lg_lp'(1);
        end
      end
      default: f_state_n = F_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      f_state <= F_IDLE;
      rr_ptr  <= '0;
      f_lock  <= '0;
      fcnt    <= '0;
    end else begin
      f_state <= f_state_n;
      rr_ptr  <= rr_ptr_n;
      f_lock  <= f_lock_n;
      fcnt    <= fcnt_n;
    end
  end

  // Reverse path: the header's cid picks the destination channel; body flits follow the lock.
  always_comb begin
    r_dest          = rev_data_i[cid_lsb +: lg_lp];
    r_sel           = (r_state == R_BUSY) ? r_lock : r_dest;
    rev_v_o         = '0;
    rev_v_o[r_sel]  = rev_v_i & reset_n_i;
    rev_ready_and_o = reset_n_i & rev_ready_and_i[r_sel];
    for (int i = 0; i < num_in_p; i++) rev_data_o[i] = rev_data_i;
    r_xfer          = rev_v_i & rev_ready_and_o;
    r_len           = rev_data_i[cid_lsb-1:len_lsb];

    r_state_n = r_state;
    r_lock_n  = r_lock;
    rcnt_n    = rcnt;
    case (r_state)
      R_IDLE: if (r_xfer && r_len != '0) begin
        r_state_n = R_BUSY;
        r_lock_n  = r_dest;
        rcnt_n    = r_len;
      end
      R_BUSY: if (r_xfer) begin
        rcnt_n = rcnt - len_width_p'(1);
        if (rcnt == len_width_p'(1)) r_state_n = R_IDLE;
      end
      default: r_state_n = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= R_IDLE;
      r_lock  <= '0;
      rcnt    <= '0;
    end else begin
      r_state <= r_state_n;
      r_lock  <= r_lock_n;
      rcnt    <= rcnt_n;
    end
  end

`ifdef BSG_WH_CONCENTRATOR_STALL_CNT_EN
  logic [31:0] stall_cnt_r;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      stall_cnt_r <= '0;
    end else if (fwd_v_o && !fwd_ready_and_i && !(&stall_cnt_r)) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end
  end

  assign stall_count_o = stall_cnt_r;
`else
  assign stall_count_o = '0;
`endif

endmodule

// File: doc/bsg_manycore_vcache_wh_concentrator.md
BSG_MANYCORE_VCACHE_WH_CONCENTRATOR -- requirements
Module: bsg_manycore_vcache_wh_concentrator

Interface
REQ-001 Parameter num_in_p, default 4, is the number of vcache DMA wormhole channels; it SHALL be a power of 2 and at least 2.
REQ-002 Parameter flit_width_p, default 32, SHALL set the flit width.
REQ-003 Parameter cord_width_p, default 8, SHALL set the width of the header cord field, flit[cord_width_p-1:0].
REQ-004 Parameter len_width_p, default 4, SHALL set the width of the header len field, located directly above cord; len is the number of body flits.
REQ-005 Parameter cid_width_p, default 2, SHALL set the width of the header cid field, located directly above len; cid_width_p SHALL be at least clog2(num_in_p).
REQ-006 Port clk_i, input, 1 bit: the single clock.
REQ-007 Port reset_n_i, input, 1 bit: reset, asynchronous and active-low.
REQ-008 Ports fwd_v_i, fwd_data_i and fwd_ready_and_o: input, input and output; 1, flit_width_p and 1 bit per channel (num_in_p channels); per-channel DMA flits in.
REQ-009 Ports fwd_v_o, fwd_data_o and fwd_ready_and_i: output, output and input; 1, flit_width_p and 1 bit; concentrated flits out.
REQ-010 Ports rev_v_i, rev_data_i and rev_ready_and_o: input, input and output; 1, flit_width_p and 1 bit; return flits in.
REQ-011 Ports rev_v_o, rev_data_o and rev_ready_and_i: output, output and input; 1, flit_width_p and 1 bit per channel (num_in_p channels); return flits out.
REQ-012 Port stall_count_o, output, 32 bits: forward-stall counter.

Function
REQ-013 Both directions SHALL use valid/ready-and handshakes; a transfer occurs only when v and ready_and are both high in the same cycle.
REQ-014 The forward FSM SHALL have two states, F_IDLE and F_BUSY.
REQ-015 In F_IDLE, the forward arbiter SHALL grant one valid channel, round-robin, starting the search at rr_ptr.
REQ-016 The granted header SHALL pass combinationally to fwd_data_o (zero latency); fwd_ready_and_o SHALL be high only for the granted channel and only when fwd_ready_and_i is high.
REQ-017 When a header with len=0 is accepted, the FSM SHALL stay in F_IDLE and rr_ptr SHALL become grant+1 mod num_in_p.
REQ-018 When a header with len>0 is accepted, the FSM SHALL move to F_BUSY, lock the grant, and load fcnt with len.
REQ-019 In F_BUSY, only the locked channel SHALL be forwarded; every accepted flit SHALL decrement fcnt.
REQ-020 In F_BUSY, the flit accepted when fcnt=1 (the tail) SHALL return the FSM to F_IDLE and set rr_ptr to lock+1 mod num_in_p.
REQ-021 In F_BUSY, if the locked channel drops v, fwd_v_o SHALL go low and the lock SHALL be held; a stall SHALL NOT change fcnt.
REQ-022 The reverse FSM SHALL have two states, R_IDLE and R_BUSY.
REQ-023 In R_IDLE, the reverse path SHALL route the header to channel d = cid[clog2(num_in_p)-1:0]; rev_ready_and_o SHALL equal rev_ready_and_i[d].
REQ-024 The reverse path SHALL apply the same len counting and locking as the forward path; rev_data_o SHALL be a combinational copy of rev_data_i.
REQ-025 Exactly one rev_v_o bit, or none, SHALL be high in any cycle.
REQ-026 The forward and reverse paths SHALL be fully independent; simultaneous forward and reverse traffic SHALL be accepted in the same cycle.
REQ-027 An input deasserting v without a transfer SHALL NOT be an error; the lock SHALL persist.

Reset
REQ-028 While reset_n_i is low, both FSMs SHALL be in IDLE, rr_ptr, fcnt, rcnt and stall_count_o SHALL be 0, and all v_o and ready_and_o outputs SHALL be 0, asynchronously.
REQ-029 Reset asserted mid-packet SHALL abandon the packet; after release, the next accepted flit on each path SHALL be treated as a header.

Configuration
REQ-030 With BSG_WH_CONCENTRATOR_STALL_CNT_EN defined, stall_count_o SHALL increment by one every cycle in which fwd_v_o=1 and fwd_ready_and_i=0, saturating at 32'hFFFFFFFF.
REQ-031 Without BSG_WH_CONCENTRATOR_STALL_CNT_EN, stall_count_o SHALL be constant 0 and no counter flops SHALL be generated.

Verification (num_in_p=4, flit 32, cord 8, len 4, cid 2)
REQ-032 Ch2 sends a header with len=3 plus 3 body flits, all ready high -> 4 flits appear on fwd_data_o in 4 consecutive cycles, in order, and rr_ptr ends at 3.
REQ-033 Channels 0-3 present len=0 headers simultaneously from reset -> grants occur in order 0, 1, 2, 3 on consecutive cycles.
REQ-034 Ch0 is mid-packet (len=2) when ch1 presents a header -> ch1's fwd_ready_and_o stays 0 until the cycle after ch0's tail is accepted.
REQ-035 fwd_ready_and_i is held 0 for 3 cycles mid-packet -> fwd_data_o is stable, fcnt is unchanged, and stall_count_o=3 (macro on) or 0 (macro off).
REQ-036 A rev header with cid=3 and len=1 arrives while rev_ready_and_i[3]=0 -> rev_v_o=4'b1000 and rev_ready_and_o=0; when rev_ready_and_i[3] rises, 2 flits are delivered to ch3 only.
REQ-037 reset_n_i is pulsed low mid-packet on both paths -> all v and ready outputs are 0 during reset; after release, ch1 with len=0 is granted first and its flit is treated as a header.
